// File: rtl/fifo_rd_adapter.sv
// Read-side adapter for a non-showahead, output-registered FIFO: issues credit-limited dequeues,
// tracks reads over the fixed FIFO read latency and presents returned words as a valid/ready stream.
module fifo_rd_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_deq,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int SKID_DEPTH = RD_LATENCY + 1;
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + RD_LATENCY + 1);

  logic [RD_LATENCY-1:0] inflight;
  logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         inflight_count;
  logic [CW-1:0]         credit_used;
  logic                  land;
  logic                  pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every read already issued, including the one landing now, holds a slot in the skid buffer,
  // so the buffer can never be asked to accept more words than it has entries.
  always_comb begin
    inflight_count = '0;
    for (int k = 0; k < RD_LATENCY; k++) begin
      inflight_count = inflight_count + CW'(inflight[k]);
    end
    land        = inflight[RD_LATENCY-1];
    pop         = o_valid & i_ready;
    credit_used = occupancy + inflight_count - CW'(pop);
    o_fifo_deq  = !reset && !i_fifo_empty && (credit_used < CW'(SKID_DEPTH));
  end

  assign o_valid = (occupancy != '0);
  assign o_data  = skid_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int k = 0; k < SKID_DEPTH; k++) begin
        skid_mem[k] <= '0;
      end
    end else begin
      inflight[0] <= o_fifo_deq;
      for (int k = 1; k < RD_LATENCY; k++) begin
        inflight[k] <= inflight[k-1];
      end
      if (land) begin
        skid_mem[wr_ptr] <= i_fifo_data;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      occupancy <= occupancy + CW'(land) - CW'(pop);
    end
  end

  no_capture_when_full: assert property (@(posedge clock) disable iff (reset)
    !(land && (occupancy == CW'(SKID_DEPTH))));

  no_deq_when_empty: assert property (@(posedge clock) disable iff (reset)
    !(o_fifo_deq && i_fifo_empty));

endmodule
